// File: rtl/io_map_pkg.sv
// I/O window map shared by the load/store controller's decode and io_responder.
package io_map_pkg;

  // Base of the memory-mapped I/O window; the low 10 bits select the register.
  localparam logic [31:0] IO_BASE = 32'hFFFFFC00;

  // Byte offsets of the board registers inside the window.
  localparam logic [9:0] IO_SW      = 10'h000;
  localparam logic [9:0] IO_LED     = 10'h004;
  localparam logic [9:0] IO_BTN_EVT = 10'h008;
  localparam logic [9:0] IO_TIMER   = 10'h00C;
  localparam logic [9:0] IO_SEG     = 10'h010;

  // Word index of an offset; byte lanes are not decoded.
  function automatic logic [7:0] io_word(input logic [9:0] offset);
    return offset[9:2];
  endfunction

  // True when a full address falls inside the I/O window.
  function automatic logic io_hit(input logic [31:0] addr);
    return addr[31:10] == IO_BASE[31:10];
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchronizer followed by a per-bit debounce down-counter.
// A bit's level flips only after DEB_CYCLES consecutive mismatching samples.
module io_debounce
  import io_map_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int DEB_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] level_q, level_d;
  logic [CW-1:0]    remain_q [WIDTH];
  logic [CW-1:0]    remain_d [WIDTH];

  // Synchronizer chain for the asynchronous raw inputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count remaining mismatches; any agreeing sample reloads the count.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < WIDTH; i++) begin
      remain_d[i] = remain_q[i];
      if (sync2_q[i] == level_q[i]) begin
        remain_d[i] = RELOAD;
      end else if (remain_q[i] == '0) begin
        level_d[i]  = ~level_q[i];
        remain_d[i] = RELOAD;
      end else begin
        remain_d[i] = remain_q[i] - CW'(1);
      end
    end
  end

  // Debounced level and counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      level_q <= '0;
      for (int i = 0; i < WIDTH; i++) remain_q[i] <= RELOAD;
    end else begin
      level_q <= level_d;
      for (int i = 0; i < WIDTH; i++) remain_q[i] <= remain_d[i];
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O responder: switches, LEDs, button events, tick timer
// and seven-segment value. Reads return registered one cycle after the strobe.
module io_responder
  import io_map_pkg::*;
#(
  parameter int SW_W        = 16,
  parameter int LED_W       = 16,
  parameter int BTN_W       = 5,
  parameter int DEB_CYCLES  = 20000,
  parameter int TICK_CYCLES = 10000
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             io_read_i,
  input  logic             io_write_i,
  input  logic [9:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             rvalid_o,
  input  logic [SW_W-1:0]  sw_i,
  input  logic [BTN_W-1:0] btn_i,
  output logic [LED_W-1:0] led_o,
  output logic [31:0]      seg_val_o
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  logic [7:0]       word;
  logic             unused_addr_lsb;
  logic [SW_W-1:0]  sw_deb;
  logic [BTN_W-1:0] btn_deb, btn_prev_q, btn_rise;
  logic [BTN_W-1:0] evt_q, evt_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      seg_q, seg_d;
  logic [31:0]      timer_q, timer_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [31:0]      rd_word;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q;
  logic             wr_led, wr_seg, wr_timer, rd_btn;

  // Byte lane bits are deliberately not decoded: sub-word stores act as word writes.
  assign word            = addr_i[9:2];
  assign unused_addr_lsb = &{1'b0, addr_i[1:0]};

  assign wr_led   = io_write_i && (word == io_word(IO_LED));
  assign wr_seg   = io_write_i && (word == io_word(IO_SEG));
  assign wr_timer = io_write_i && (word == io_word(IO_TIMER));
  assign rd_btn   = io_read_i  && (word == io_word(IO_BTN_EVT));

  io_debounce #(.WIDTH(SW_W), .DEB_CYCLES(DEB_CYCLES)) u_sw_deb (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .raw_i   (sw_i),
    .level_o (sw_deb)
  );

  io_debounce #(.WIDTH(BTN_W), .DEB_CYCLES(DEB_CYCLES)) u_btn_deb (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .raw_i   (btn_i),
    .level_o (btn_deb)
  );

  // Read mux over the pre-edge register contents.
  always_comb begin
    rd_word = '0;
    case (word)
      io_word(IO_SW):      rd_word = 32'(sw_deb);
      io_word(IO_LED):     rd_word = 32'(led_q);
      io_word(IO_BTN_EVT): rd_word = 32'(evt_q);
      io_word(IO_TIMER):   rd_word = timer_q;
      io_word(IO_SEG):     rd_word = seg_q;
      default:             rd_word = '0;
    endcase
  end

  // Next-state for read data, button events and writable registers.
  always_comb begin
    rdata_d  = io_read_i ? rd_word : rdata_q;
    btn_rise = btn_deb & ~btn_prev_q;
    // A rising edge in the same cycle as the clearing read survives the clear.
    evt_d    = (rd_btn ? '0 : evt_q) | btn_rise;
    led_d    = wr_led ? wdata_i[LED_W-1:0] : led_q;
    seg_d    = wr_seg ? wdata_i : seg_q;
  end

  // Timer: prescaler wrap advances TIMER; a write reloads both and wins.
  always_comb begin
    timer_d = timer_q;
    presc_d = presc_q;
    if (wr_timer) begin
      timer_d = wdata_i;
      presc_d = '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      timer_d = timer_q + 32'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      btn_prev_q <= '0;
      evt_q      <= '0;
      led_q      <= '0;
      seg_q      <= '0;
      timer_q    <= '0;
      presc_q    <= '0;
    end else begin
      rdata_q    <= rdata_d;
      rvalid_q   <= io_read_i;
      btn_prev_q <= btn_deb;
      evt_q      <= evt_d;
      led_q      <= led_d;
      seg_q      <= seg_d;
      timer_q    <= timer_d;
      presc_q    <= presc_d;
    end
  end

  assign rdata_o   = rdata_q;
  assign rvalid_o  = rvalid_q;
  assign led_o     = led_q;
  assign seg_val_o = seg_q;

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder with a behavioural register model.
module tb_io_responder;

  localparam int DEB  = 4;
  localparam int TICK = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_read, io_write;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic [15:0] sw;
  logic [4:0]  btn;
  logic [15:0] led;
  logic [31:0] seg;

  int tests  = 0;
  int errors = 0;

  io_responder #(
    .SW_W(16), .LED_W(16), .BTN_W(5), .DEB_CYCLES(DEB), .TICK_CYCLES(TICK)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .io_read_i(io_read), .io_write_i(io_write),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .rvalid_o(rvalid),
    .sw_i(sw), .btn_i(btn), .led_o(led), .seg_val_o(seg)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_rdata, m_timer, m_seg;
  logic        m_rvalid;
  logic [15:0] m_led;
  logic [4:0]  m_evt, m_btn_lvl, m_btn_prev, m_rise;
  int          m_presc;
  logic [15:0] m_sw_lvl, m_sw_r1, m_sw_r2, m_sw_mask;
  logic [4:0]  m_btn_r1, m_btn_r2, m_btn_mask;
  logic [15:0] sw_hist[$];
  logic [4:0]  btn_hist[$];

  function automatic logic [31:0] m_read(input logic [9:0] a);
    case (a[9:2])
      8'h00:   return {16'b0, m_sw_lvl};
      8'h01:   return {16'b0, m_led};
      8'h02:   return {27'b0, m_evt};
      8'h03:   return m_timer;
      8'h04:   return m_seg;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdata = 0; m_rvalid = 0; m_timer = 0; m_seg = 0; m_led = 0; m_presc = 0;
      m_evt = 0; m_btn_lvl = 0; m_btn_prev = 0; m_sw_lvl = 0;
      m_sw_r1 = 0; m_sw_r2 = 0; m_btn_r1 = 0; m_btn_r2 = 0;
      sw_hist = {}; btn_hist = {};
      for (int i = 0; i < DEB; i++) begin
        sw_hist.push_back(16'h0);
        btn_hist.push_back(5'h0);
      end
    end else begin
      if (io_read) m_rdata = m_read(addr);
      m_rvalid = io_read;
      m_rise = m_btn_lvl & ~m_btn_prev;
      m_btn_prev = m_btn_lvl;
      m_evt = ((io_read && addr[9:2] == 8'h02) ? 5'h0 : m_evt) | m_rise;
      if (io_write && addr[9:2] == 8'h03) begin
        m_timer = wdata;
        m_presc = 0;
      end else begin
        m_presc = m_presc + 1;
        if (m_presc == TICK) begin
          m_presc = 0;
          m_timer = m_timer + 1;
        end
      end
      if (io_write && addr[9:2] == 8'h01) m_led = wdata[15:0];
      if (io_write && addr[9:2] == 8'h04) m_seg = wdata;
      // level flips where the last DEB synchronized samples all disagree with it
      sw_hist.push_back(m_sw_r2);  sw_hist.delete(0);
      btn_hist.push_back(m_btn_r2); btn_hist.delete(0);
      m_sw_mask = 16'hFFFF;
      m_btn_mask = 5'h1F;
      foreach (sw_hist[i])  m_sw_mask  &= sw_hist[i] ^ m_sw_lvl;
      foreach (btn_hist[i]) m_btn_mask &= btn_hist[i] ^ m_btn_lvl;
      m_sw_lvl  ^= m_sw_mask;
      m_btn_lvl ^= m_btn_mask;
      m_sw_r2 = m_sw_r1;  m_sw_r1 = sw;
      m_btn_r2 = m_btn_r1; m_btn_r1 = btn;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of every visible output against the model.
  always @(negedge clk) begin
    chk("cmp_rdata", rdata, m_rdata);
    chk("cmp_rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
    chk("cmp_led", {16'b0, led}, {16'b0, m_led});
    chk("cmp_seg", seg, m_seg);
  end

  // ---------------- stimulus ----------------
  task automatic rd(input logic [9:0] a, input logic [31:0] exp, input string name);
    io_read = 1'b1;
    addr = a;
    @(negedge clk);
    io_read = 1'b0;
    chk(name, rdata, exp);
    chk({name, "_valid"}, {31'b0, rvalid}, 32'h1);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    io_write = 1'b1;
    addr = a;
    wdata = d;
    @(negedge clk);
    io_write = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; io_read = 0; io_write = 0; addr = 0; wdata = 0; sw = 0; btn = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_led", {16'b0, led}, 32'h0);
    chk("rst_seg", seg, 32'h0);
    rst_n = 1'b1;

    // reads straight out of reset
    rd(10'h004, 32'h0, "rst_rd_led");
    rd(10'h010, 32'h0, "rst_rd_seg");
    rd(10'h00C, 32'h0, "rst_rd_timer");
    @(negedge clk);
    chk("rvalid_drop", {31'b0, rvalid}, 32'h0);

    // LED / SEG write and readback, byte lanes ignored
    wr(10'h004, 32'hDEADBEEF);
    chk("led_after_wr", {16'b0, led}, 32'h0000BEEF);
    rd(10'h004, 32'h0000BEEF, "rd_led");
    rd(10'h006, 32'h0000BEEF, "rd_led_lsb");
    wr(10'h010, 32'h12345678);
    chk("seg_after_wr", seg, 32'h12345678);
    rd(10'h010, 32'h12345678, "rd_seg");
    wr(10'h013, 32'hCAFEF00D);
    rd(10'h010, 32'hCAFEF00D, "rd_seg_byte_store");

    // switch debounce with a two-cycle glitch
    sw = 16'h00A5;
    @(negedge clk);
    sw = 16'h00FF;
    repeat (2) @(negedge clk);
    sw = 16'h00A5;
    rd(10'h000, 32'h0, "sw_e4");
    rd(10'h000, 32'h0, "sw_e5");
    rd(10'h000, 32'h0, "sw_e6");
    rd(10'h000, 32'h00A5, "sw_e7");
    for (int i = 0; i < 3; i++) rd(10'h000, 32'h00A5, "sw_stable");

    // button 2 pressed for 10 cycles
    btn = 5'b00100;
    repeat (10) @(negedge clk);
    btn = 5'b0;
    repeat (12) @(negedge clk);
    rd(10'h008, 32'h04, "btn_evt");
    rd(10'h008, 32'h00, "btn_evt_cleared");
    // new edge coincides with the clearing read
    btn = 5'b00100;
    repeat (6) @(negedge clk);
    rd(10'h008, 32'h00, "btn_same_cycle_read");
    rd(10'h008, 32'h04, "btn_edge_kept");
    rd(10'h008, 32'h00, "btn_recleared");
    btn = 5'b0;
    repeat (10) @(negedge clk);

    // timer write beats a same-cycle increment
    wr(10'h00C, 32'hFFFFFFFE);
    repeat (2) @(negedge clk);
    wr(10'h00C, 32'd100);
    rd(10'h00C, 32'd100, "timer_wr_wins");
    // timer wrap with restarted prescaler
    wr(10'h00C, 32'hFFFFFFFE);
    rd(10'h00C, 32'hFFFFFFFE, "timer_k1");
    rd(10'h00C, 32'hFFFFFFFE, "timer_k2");
    rd(10'h00C, 32'hFFFFFFFE, "timer_k3");
    rd(10'h00C, 32'hFFFFFFFF, "timer_k4");
    rd(10'h00C, 32'hFFFFFFFF, "timer_k5");
    rd(10'h00C, 32'hFFFFFFFF, "timer_k6");
    rd(10'h00C, 32'h00000000, "timer_wrap");

    // unmapped offset and read-only registers
    wr(10'h3FC, 32'hFFFFFFFF);
    rd(10'h3FC, 32'h0, "rd_unmapped");
    chk("led_untouched", {16'b0, led}, 32'h0000BEEF);
    chk("seg_untouched", seg, 32'hCAFEF00D);
    wr(10'h000, 32'h1234);
    rd(10'h000, 32'h00A5, "sw_wr_ignored");
    wr(10'h008, 32'h1F);
    rd(10'h008, 32'h0, "btn_wr_ignored");

    // simultaneous read and write on LED
    io_read = 1'b1; io_write = 1'b1; addr = 10'h004; wdata = 32'h00001234;
    @(negedge clk);
    io_read = 1'b0; io_write = 1'b0;
    chk("rw_old_value", rdata, 32'h0000BEEF);
    chk("rw_led_written", {16'b0, led}, 32'h00001234);

    // asynchronous reset with a read response pending
    io_read = 1'b1; addr = 10'h004;
    @(posedge clk);
    #1 io_read = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_led", {16'b0, led}, 32'h0);
    chk("mid_rst_seg", seg, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(10'h004, 32'h0, "post_rst_led");
    rd(10'h000, 32'h0, "post_rst_sw");
    rd(10'h00C, 32'h0, "post_rst_timer");
    repeat (8) @(negedge clk);
    rd(10'h000, 32'h00A5, "post_rst_sw_deb");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
